// File: rtl/bit_speck128_128_hierarchy_carry_sharing.sv
// Bit-serial Speck128/128 on two Boolean shares with a share-split carry per adder.
// Optional SPECK_OUTPUT_GATE_EN holds the cipher outputs at zero until the 32 rounds are done.
module bit_speck128_128_hierarchy_carry_sharing (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_ina,
   input  logic       data_inb,
   input  logic       k_data_ina,
   input  logic       k_data_inb,
   input  logic       carry_init_a,
   input  logic       carry_init_b,
   input  logic       we,
   input  logic       Start,
   output logic [1:0] cipher_out1,
   output logic [1:0] cipher_out2,
   output logic       rndlessthan32
);
   // Index 0 is share a, index 1 is share b.
   logic [1:0][63:0] x_q, y_q, l_q, k_q;
   logic [1:0][62:0] xn_q, yn_q, ln_q, kn_q;
   logic [1:0]       cx_q, cl_q;
   logic [5:0]       bit_q, rnd_q;

   logic [5:0] idx_r8, idx_l3;
   logic [1:0] din, kin;
   logic [1:0] xr, yj, yl3, lr, kj, kl3;
   logic [1:0] cx_t, cl_t, sx, sl;
   logic [1:0] xnew, ynew, lnew, knew;
   logic [1:0] cx_d, cl_d;
   logic [7:0] rc8;
   logic       ibit;
   logic       running;

   // Share s of maj(a,b,c): own a/b bits times the recombined partner operands.
   function automatic logic mmaj(input logic a_s, input logic b_s,
                                 input logic [1:0] b, input logic [1:0] c);
      return (a_s & (^b)) ^ (a_s & (^c)) ^ (b_s & (^c));
   endfunction

   assign idx_r8  = bit_q + 6'd8;
   assign idx_l3  = bit_q - 6'd3;
   assign din     = {data_inb, data_ina};
   assign kin     = {k_data_inb, k_data_ina};
   assign running = (rnd_q < 6'd32);

   // The register holds the true carry share; share a is offset by one on entry.
   assign cx_t = (bit_q == 6'd0) ? {carry_init_b, ~carry_init_a} : cx_q;
   assign cl_t = (bit_q == 6'd0) ? {carry_init_b, ~carry_init_a} : cl_q;

   assign rc8  = {3'b000, rnd_q[4:0]};
   assign ibit = (bit_q[5:3] == 3'd0) & rc8[bit_q[2:0]];

   for (genvar gi = 0; gi < 2; gi++) begin : g_share
      assign xr[gi]   = x_q[gi][idx_r8];
      assign yj[gi]   = y_q[gi][bit_q];
      assign yl3[gi]  = y_q[gi][idx_l3];
      assign lr[gi]   = l_q[gi][idx_r8];
      assign kj[gi]   = k_q[gi][bit_q];
      assign kl3[gi]  = k_q[gi][idx_l3];
      assign sx[gi]   = xr[gi] ^ yj[gi] ^ cx_t[gi];
      assign sl[gi]   = lr[gi] ^ kj[gi] ^ cl_t[gi];
      assign xnew[gi] = sx[gi] ^ kj[gi];
      assign ynew[gi] = yl3[gi] ^ xnew[gi];
      assign knew[gi] = kl3[gi] ^ lnew[gi];
      assign cx_d[gi] = mmaj(xr[gi], yj[gi], yj, cx_t);
      assign cl_d[gi] = mmaj(lr[gi], kj[gi], kj, cl_t);
   end

   assign lnew = {sl[1], sl[0] ^ ibit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q   <= '0;
         y_q   <= '0;
         l_q   <= '0;
         k_q   <= '0;
         xn_q  <= '0;
         yn_q  <= '0;
         ln_q  <= '0;
         kn_q  <= '0;
         cx_q  <= '0;
         cl_q  <= '0;
         bit_q <= '0;
         rnd_q <= '0;
      end else if (we) begin
         for (int s = 0; s < 2; s++) begin
            x_q[s] <= {din[s], x_q[s][63:1]};
            y_q[s] <= {x_q[s][0], y_q[s][63:1]};
            l_q[s] <= {kin[s], l_q[s][63:1]};
            k_q[s] <= {l_q[s][0], k_q[s][63:1]};
         end
         cx_q  <= '0;
         cl_q  <= '0;
         bit_q <= '0;
         rnd_q <= '0;
      end else if (Start) begin
         if (running) begin
            // New words assemble in the side buffers; the live words stay
            // readable at rotated offsets until the last bit of the round.
            for (int s = 0; s < 2; s++) begin
               xn_q[s] <= {xnew[s], xn_q[s][62:1]};
               yn_q[s] <= {ynew[s], yn_q[s][62:1]};
               ln_q[s] <= {lnew[s], ln_q[s][62:1]};
               kn_q[s] <= {knew[s], kn_q[s][62:1]};
               if (bit_q == 6'd63) begin
                  x_q[s] <= {xnew[s], xn_q[s]};
                  y_q[s] <= {ynew[s], yn_q[s]};
                  l_q[s] <= {lnew[s], ln_q[s]};
                  k_q[s] <= {knew[s], kn_q[s]};
               end
            end
            cx_q  <= cx_d;
            cl_q  <= cl_d;
            bit_q <= bit_q + 6'd1;
            if (bit_q == 6'd63) begin
               rnd_q <= rnd_q + 6'd1;
            end
         end else begin
            for (int s = 0; s < 2; s++) begin
               x_q[s] <= {x_q[s][0], x_q[s][63:1]};
               y_q[s] <= {y_q[s][0], y_q[s][63:1]};
            end
         end
      end
   end

   assign rndlessthan32 = running;

`ifdef SPECK_OUTPUT_GATE_EN
   assign cipher_out1 = running ? 2'b00 : {x_q[0][0], y_q[0][0]};
   assign cipher_out2 = running ? 2'b00 : {x_q[1][0], y_q[1][0]};
`else
   assign cipher_out1 = {x_q[0][0], y_q[0][0]};
   assign cipher_out2 = {x_q[1][0], y_q[1][0]};
`endif

endmodule

// File: tb/tb_bit_speck128_128_hierarchy_carry_sharing.sv
// Directed bench for the masked bit-serial Speck128/128 core: KAT, masking, timing, pause, reset, abort.
module tb_bit_speck128_128_hierarchy_carry_sharing;
   logic       clk = 1'b0;
   logic       rst;
   logic       data_ina, data_inb, k_data_ina, k_data_inb;
   logic       carry_init_a, carry_init_b, we, Start;
   logic [1:0] cipher_out1, cipher_out2;
   logic       rndlessthan32;

   int n_checks = 0;
   int n_err    = 0;

   localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] KAT_PT  = 128'h6c617669757165207469206564616d20;
   localparam logic [127:0] KAT_CT  = 128'ha65d9851797832657860fedf5c570d18;

   typedef struct {
      logic [127:0] key;
      logic [127:0] kmask;
      logic [127:0] pt;
      logic [127:0] pmask;
      logic         cia;
      logic         cib;
      logic [127:0] ct;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   bit_speck128_128_hierarchy_carry_sharing dut (
      .clk          (clk),
      .rst          (rst),
      .data_ina     (data_ina),
      .data_inb     (data_inb),
      .k_data_ina   (k_data_ina),
      .k_data_inb   (k_data_inb),
      .carry_init_a (carry_init_a),
      .carry_init_b (carry_init_b),
      .we           (we),
      .Start        (Start),
      .cipher_out1  (cipher_out1),
      .cipher_out2  (cipher_out2),
      .rndlessthan32(rndlessthan32)
   );

   // Plain word-parallel reference used for the non-KAT vectors.
   function automatic logic [127:0] speck_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [63:0] x, y, l, k;
      x = pt[127:64];
      y = pt[63:0];
      l = key[127:64];
      k = key[63:0];
      for (int i = 0; i < 32; i++) begin
         x = ({x[7:0], x[63:8]} + y) ^ k;
         y = {y[60:0], y[63:61]} ^ x;
         l = ({l[7:0], l[63:8]} + k) ^ 64'(i);
         k = {k[60:0], k[63:61]} ^ l;
      end
      return {x, y};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic load(input logic [127:0] pa, input logic [127:0] pb,
                       input logic [127:0] ka, input logic [127:0] kb,
                       input logic cia, input logic cib);
      we = 1'b1;
      Start = 1'b0;
      carry_init_a = cia;
      carry_init_b = cib;
      for (int i = 0; i < 128; i++) begin
         data_ina   = pa[i];
         data_inb   = pb[i];
         k_data_ina = ka[i];
         k_data_inb = kb[i];
         tick();
      end
      we = 1'b0;
   endtask

   task automatic load_vec(input vec_t v);
      load(v.pt ^ v.pmask, v.pmask, v.key ^ v.kmask, v.kmask, v.cia, v.cib);
   endtask

   // Start-high clocks until rndlessthan32 drops; -1 if it never does within the bound.
   task automatic run_rounds(input int limit, output int fall);
      Start = 1'b1;
      fall = -1;
      for (int c = 1; c <= limit && fall < 0; c++) begin
         tick();
         if (!rndlessthan32) fall = c;
      end
   endtask

   task automatic stream(output logic [127:0] ct, output logic [127:0] sa);
      Start = 1'b1;
      for (int b = 0; b < 64; b++) begin
         ct[64+b] = cipher_out1[1] ^ cipher_out2[1];
         ct[b]    = cipher_out1[0] ^ cipher_out2[0];
         sa[64+b] = cipher_out1[1];
         sa[b]    = cipher_out1[0];
         tick();
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           fall;
      int           changes;
      int           nonzero;
      logic [127:0] ct, sa;
      logic [4:0]   prev;

      vecs[0] = '{KAT_KEY, 128'h0, KAT_PT, 128'h0, 1'b1, 1'b0, KAT_CT};
      vecs[1] = '{KAT_KEY, 128'h5a5a1234deadbeef0f1e2d3c4b5a6978,
                  KAT_PT,  128'hc3a5968778695a4b3c2d1e0ff0e1d2c3, 1'b1, 1'b0, KAT_CT};
      vecs[2] = '{KAT_KEY, 128'h13579bdf2468ace0fedcba9876543210,
                  KAT_PT,  128'h9e3779b97f4a7c15f39cc0605cedc834, 1'b0, 1'b1, KAT_CT};
      vecs[3] = '{128'h0, 128'h0, 128'h0, 128'h0, 1'b1, 1'b0, speck_ref(128'h0, 128'h0)};
      vecs[4] = '{128'h0123456789abcdeffedcba9876543210, 128'h0badf00dcafebabe1122334455667788,
                  128'h00112233445566778899aabbccddeeff, 128'h8877665544332211a1b2c3d4e5f60718,
                  1'b1, 1'b0,
                  speck_ref(128'h0123456789abcdeffedcba9876543210,
                            128'h00112233445566778899aabbccddeeff)};

      rst = 1'b1;
      we = 1'b0;
      Start = 1'b0;
      data_ina = 1'b0;
      data_inb = 1'b0;
      k_data_ina = 1'b0;
      k_data_inb = 1'b0;
      carry_init_a = 1'b1;
      carry_init_b = 1'b0;
      tick();
      tick();
      chk("reset_out1", 128'(cipher_out1), 128'h0);
      chk("reset_out2", 128'(cipher_out2), 128'h0);
      chk("reset_rnd",  128'(rndlessthan32), 128'h1);
      rst = 1'b0;
      tick();

      // Table-driven vectors: load, 32 rounds, stream and recombine the shares.
      for (int v = 0; v < 5; v++) begin
         load_vec(vecs[v]);
         run_rounds(2100, fall);
         chk($sformatf("v%0d_fall_cycle", v), 128'(fall), 128'd2048);
         stream(ct, sa);
         chk($sformatf("v%0d_cipher", v), ct, vecs[v].ct);
         if (vecs[v].pmask != 128'h0)
            chk($sformatf("v%0d_share_a_differs", v), 128'(sa !== ct), 128'h1);
         Start = 1'b0;
      end

      // Pause at round 10 for 100 clocks.
      load_vec(vecs[0]);
      Start = 1'b1;
      changes = 0;
      nonzero = 0;
      prev = {cipher_out1, cipher_out2, rndlessthan32};
      for (int c = 0; c < 640; c++) begin
         tick();
         if ({cipher_out1, cipher_out2} != prev[4:1]) changes++;
         if ({cipher_out1, cipher_out2} != 4'h0) nonzero++;
         prev = {cipher_out1, cipher_out2, rndlessthan32};
      end
`ifdef SPECK_OUTPUT_GATE_EN
      chk("gated_outputs_zero", 128'(nonzero), 128'd0);
`else
      chk("outputs_toggle", 128'(changes > 0), 128'h1);
`endif
      Start = 1'b0;
      changes = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if ({cipher_out1, cipher_out2, rndlessthan32} != prev) changes++;
      end
      chk("pause_frozen", 128'(changes), 128'd0);
      run_rounds(1500, fall);
      chk("pause_remaining_cycles", 128'(fall), 128'd1408);
      stream(ct, sa);
      chk("pause_cipher", ct, KAT_CT);
      Start = 1'b0;

      // Asynchronous reset at round 15, then reload and rerun.
      load_vec(vecs[1]);
      Start = 1'b1;
      repeat (960) tick();
      #3 rst = 1'b1;
      #1;
      chk("midrst_out1", 128'(cipher_out1), 128'h0);
      chk("midrst_out2", 128'(cipher_out2), 128'h0);
      chk("midrst_rnd",  128'(rndlessthan32), 128'h1);
      tick();
      tick();
      rst = 1'b0;
      Start = 1'b0;
      tick();
      load_vec(vecs[1]);
      run_rounds(2100, fall);
      chk("after_rst_fall_cycle", 128'(fall), 128'd2048);
      stream(ct, sa);
      chk("after_rst_cipher", ct, KAT_CT);
      Start = 1'b0;

      // Reload mid-encryption aborts the run; the stream repeats every 64 clocks.
      load_vec(vecs[3]);
      Start = 1'b1;
      repeat (300) tick();
      load_vec(vecs[2]);
      run_rounds(2100, fall);
      chk("abort_fall_cycle", 128'(fall), 128'd2048);
      stream(ct, sa);
      chk("abort_cipher", ct, KAT_CT);
      stream(ct, sa);
      chk("repeat_cipher", ct, KAT_CT);
      Start = 1'b0;
      tick();
      chk("saturated_rnd", 128'(rndlessthan32), 128'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
